fetch_sequencer: RTL and testbench

- Sequences the program counter and fetch stage.
- Decides each cycle whether the PC flop loads `next_pc` and whether the fetched instruction issues to decode or becomes a bubble.
- Inserts the bubbles needed while a jump-register target (1 cycle) or a conditional branch outcome (2 cycles) is resolved.
- Stalls on instruction-memory wait or a downstream stall, and tracks call-stack occupancy with overflow/underflow detection.

---
 rtl/fetch_sequencer.sv | 162 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// PC / fetch sequencer: issue-or-bubble control, jump-register and branch resolution
// bubbles, memory/downstream stalls, and call-stack occupancy tracking.
// Optional stall-cycle counter enabled by `define FETCH_STALL_COUNT_EN.
module fetch_sequencer #(
  parameter int unsigned DEPTH_BITS = 4,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  imem_ready,
  input  logic                  ext_stall,
  input  logic                  is_jump_reg,
  input  logic                  is_branch,
  input  logic                  push_stack,
  input  logic                  pop_stack,
  input  logic                  branch_taken,
  output logic                  pc_enable,
  output logic                  issue_valid,
  output logic                  flush,
  output logic [2:0]            state,
  output logic [DEPTH_BITS:0]   stack_depth,
  output logic                  stack_overflow,
  output logic                  stack_underflow,
  output logic [CNT_WIDTH-1:0]  stall_cycles
);

  localparam int unsigned DW = DEPTH_BITS + 1;
  localparam logic [DW-1:0] DEPTH_MAX = DW'(1 << DEPTH_BITS);

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_JR_WAIT  = 3'd1,
    ST_BR_WAIT1 = 3'd2,
    ST_BR_WAIT2 = 3'd3,
    ST_MEM_WAIT = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and fetch control; outputs are forced low while reset is held
  always_comb begin
    state_d     = state_q;
    pc_enable   = 1'b0;
    issue_valid = 1'b0;
    flush       = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!imem_ready) begin
          state_d = ST_MEM_WAIT;
        end else if (!ext_stall) begin
          pc_enable   = 1'b1;
          issue_valid = 1'b1;
          if (is_jump_reg) begin
            state_d = ST_JR_WAIT;
          end else if (is_branch) begin
            state_d = ST_BR_WAIT1;
          end
        end
      end
      ST_JR_WAIT: begin
        if (!ext_stall) begin
          pc_enable = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_BR_WAIT1: begin
        if (!ext_stall) begin
          state_d = ST_BR_WAIT2;
        end
      end
      ST_BR_WAIT2: begin
        if (!ext_stall) begin
          pc_enable = 1'b1;
          flush     = branch_taken;
          state_d   = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (imem_ready) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    if (reset) begin
      pc_enable   = 1'b0;
      issue_valid = 1'b0;
      flush       = 1'b0;
    end
  end

  // Call-stack occupancy: only issued instructions push or pop
  always_comb begin
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (issue_valid) begin
      if (push_stack && !pop_stack) begin
        if (depth_q < DEPTH_MAX) begin
          depth_d = depth_q + DW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end else if (pop_stack && !push_stack) begin
        if (depth_q != '0) begin
          depth_d = depth_q - DW'(1);
        end else begin
          unf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign state           = 3'(state_q);
  assign stack_depth     = depth_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

`ifdef FETCH_STALL_COUNT_EN
  logic [CNT_WIDTH-1:0] stall_q;

  // Counts every non-issuing cycle out of reset; wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (!issue_valid) begin
      stall_q <= stall_q + CNT_WIDTH'(1);
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized self-checking bench for fetch_sequencer against a pending-resolution
// reference model (bubbles remaining per outstanding jump/branch).
module tb_fetch_sequencer;

  localparam int unsigned DB  = 2;
  localparam int unsigned CW  = 32;
  localparam int          CAP = 1 << DB;

  logic clk = 1'b0;
  logic reset, imem_ready, ext_stall, is_jump_reg, is_branch;
  logic push_stack, pop_stack, branch_taken;
  logic pc_enable, issue_valid, flush;
  logic [2:0]    state;
  logic [DB:0]   stack_depth;
  logic          stack_overflow, stack_underflow;
  logic [CW-1:0] stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: outstanding resolution kind and how many cycles it still needs
  bit      m_mem;      // waiting for instruction memory
  int      m_pend;     // 0 none, 1 jump-register, 2 branch
  int      m_left;     // branch: resolution cycles remaining (2 then 1)
  int      m_depth;
  bit      m_ovf, m_unf;
  longint  m_stall;

  fetch_sequencer #(.DEPTH_BITS(DB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .imem_ready(imem_ready), .ext_stall(ext_stall),
    .is_jump_reg(is_jump_reg), .is_branch(is_branch), .push_stack(push_stack),
    .pop_stack(pop_stack), .branch_taken(branch_taken), .pc_enable(pc_enable),
    .issue_valid(issue_valid), .flush(flush), .state(state),
    .stack_depth(stack_depth), .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_mem = 0; m_pend = 0; m_left = 0; m_depth = 0;
    m_ovf = 0; m_unf = 0; m_stall = 0;
  endtask

  // One clock: drive, check at negedge against model, advance model, cross posedge
  task automatic step(input bit rst, input bit imr, input bit stl, input bit jr,
                      input bit br, input bit psh, input bit pp, input bit tk);
    bit e_pe, e_iv, e_fl;
    int e_st;
    reset = rst; imem_ready = imr; ext_stall = stl; is_jump_reg = jr;
    is_branch = br; push_stack = psh; pop_stack = pp; branch_taken = tk;
    if (rst) model_clear();
    e_pe = 0; e_iv = 0; e_fl = 0;
    if (!rst) begin
      if (m_mem) begin
        e_pe = 0;
      end else if (m_pend == 0) begin
        e_iv = imr && !stl;
        e_pe = e_iv;
      end else if (m_pend == 1) begin
        e_pe = !stl;
      end else if (m_left == 1) begin
        e_pe = !stl;
        e_fl = !stl && tk;
      end
    end
    e_st = m_mem ? 4 : (m_pend == 1) ? 1 : (m_pend == 2) ? ((m_left == 2) ? 2 : 3) : 0;
    @(negedge clk);
    check("pc_enable", 64'(pc_enable), 64'(e_pe));
    check("issue_valid", 64'(issue_valid), 64'(e_iv));
    check("flush", 64'(flush), 64'(e_fl));
    check("state", 64'(state), 64'(e_st));
    check("stack_depth", 64'(stack_depth), 64'(m_depth));
    check("overflow", 64'(stack_overflow), 64'(m_ovf));
    check("underflow", 64'(stack_underflow), 64'(m_unf));
`ifdef FETCH_STALL_COUNT_EN
    check("stall_cycles", 64'(stall_cycles), 64'(m_stall & 64'hFFFF_FFFF));
`else
    check("stall_cycles", 64'(stall_cycles), 64'd0);
`endif
    if (!rst) begin
      if (!e_iv) m_stall++;
      if (e_iv && psh && !pp) begin
        if (m_depth < CAP) m_depth++; else m_ovf = 1;
      end else if (e_iv && pp && !psh) begin
        if (m_depth > 0) m_depth--; else m_unf = 1;
      end
      if (m_mem) begin
        if (imr) m_mem = 0;
      end else if (m_pend == 0) begin
        if (!imr) m_mem = 1;
        else if (!stl && jr) m_pend = 1;
        else if (!stl && br) begin m_pend = 2; m_left = 2; end
      end else if (!stl) begin
        if (m_pend == 2 && m_left == 2) m_left = 1;
        else m_pend = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_clear();
    reset = 1; imem_ready = 1; ext_stall = 0; is_jump_reg = 0; is_branch = 0;
    push_stack = 0; pop_stack = 0; branch_taken = 0;
    @(posedge clk); #1;
    step(1, 1, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Reset abandons a branch wait; outputs low while held
    step(0, 1, 0, 0, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0, 0);
    check("rst_state", 64'(state), 64'd0);
    idle(1);

    // Jump-register, then taken and not-taken branches
    step(0, 1, 0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 1, 0, 0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);

    // Downstream stall held for 3 cycles in the first branch wait
    step(0, 1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    idle(1);

    // Stack saturation both ways, and simultaneous push/pop
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 1, 0, 0);
    check("depth_full", 64'(stack_depth), 64'(CAP));
    check("ovf_set", 64'(stack_overflow), 64'd1);
    step(0, 1, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 1, 0);
    check("depth_empty", 64'(stack_depth), 64'd0);
    check("unf_set", 64'(stack_underflow), 64'd1);
    step(0, 1, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0);

    // Stall counter: 4 memory-wait cycles, exit cycle, jump-register bubble
    step(1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
`ifdef FETCH_STALL_COUNT_EN
    check("stall_total", 64'(stall_cycles), 64'd6);
`else
    check("stall_total", 64'(stall_cycles), 64'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < 85),
           ($urandom_range(0, 99) < 20),
           ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 20),
           ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 30),
           1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
